command_ascii_decoder: RTL
==========================

# command_ascii_decoder

Receives a byte stream of ASCII hex commands from the UART receive path and parses each complete line into one 32-bit bus read or write request. It holds the request until the bus acknowledges it, then accepts the next command. It sits directly upstream of the bus: its `req`/`we`/`addr`/`wdata` drive the bus, and the same `ack` that completes its request also triggers the ASCII response coder downstream.

## Interface
- No parameters.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- s_tvalid  input  1  input byte valid.
- s_tdata  input  8  input ASCII byte.
- s_tready  output  1  decoder can accept a byte; combinational from state.
- req  output  1  bus request; held high until `ack`.
- we  output  1  1 = write, 0 = read; valid while `req`.
- addr  output  32  bus address; valid while `req`.
- wdata  output  32  write data; valid while `req` and `we` (0 for reads).
- ack  input  1  bus acknowledge; sampled only while `req` = 1.
- err  output  1  one-cycle pulse on a malformed command.

## Operation
- A byte is accepted on a rising edge with `s_tvalid && s_tready`.
- Command grammar, case-sensitive:
  - Read: `r`, space (0x20), 8 hex digits, LF (0x0A).
  - Write: `w`, space, 8 hex digits, space, 8 hex digits, LF.
- Hex digits are 0-9, a-f and A-F.
- CR (0x0D) is accepted and ignored in every receiving state.
- Address and data are accumulated MSB-first: `acc <= {acc[27:0], nibble}`.
- A 3-bit digit counter tracks progress; the 8th digit moves the FSM to the next field.
- States and transitions:
  - IDLE: `r` → SP1 (we=0); `w` → SP1 (we=1); LF → IDLE (empty line, no error); other → error.
  - SP1: space → ADDR (counter cleared); other → error.
  - ADDR: hex → accumulate. On the 8th digit: if read → EOL, if write → SP2. Non-hex → error.
  - SP2: space → DATA; other → error.
  - DATA: hex → accumulate; 8th digit → EOL; non-hex → error.
  - EOL: LF → REQ; other, including a 9th digit → error.
  - REQ: `req` = 1, `s_tready` = 0; on `ack` → IDLE.
  - DISCARD: accept and drop bytes until LF → IDLE. No further `err` pulses in this state.
- Error: `err` pulses for one cycle and the FSM enters DISCARD. The offending byte is consumed; if it is LF, the FSM goes directly to IDLE.
- `addr` and `wdata` are updated only on entry to REQ, so they are stable for the whole request. `wdata` = 0 for reads.
- `ack` outside REQ is ignored.

## Timing
- Reset values: state IDLE, `req` 0, `we` 0, `addr` 0, `wdata` 0, `err` 0.
- `s_tready` = 1 in every state except REQ, so it reads 1 immediately after reset deasserts.
- `req` rises on the edge that accepts the terminating LF.
- `req` falls on the edge where `ack` = 1 is sampled, and `s_tready` returns to 1 in the same cycle.
- Minimum request length is one cycle, when `ack` is already high at the first REQ edge.
- `err` is registered: it is high for exactly the cycle after the offending byte is accepted.
- Throughput: one byte per cycle while not in REQ. A read line is 11 bytes, so back-to-back reads need at least 12 cycles each.
- Reset mid-operation drops `req` and `err` immediately, abandons any partial line, and returns to IDLE.
- A partial line followed by reset leaves no residue: accumulators are cleared.

## Test plan
- Read: send "r 0000abcd\n" (LF), then assert `ack` 3 cycles later.
  - Expected: `req`=1, `we`=0, `addr`=0x0000ABCD, `wdata`=0, stable until `ack`; `req` drops at the `ack` edge; `s_tready` is 0 only during REQ.
- Write with mixed case: send "w DEADbeef 12345678\r\n".
  - Expected: `we`=1, `addr`=0xDEADBEEF, `wdata`=0x12345678; CR is ignored; no `err`.
- Malformed lines:
  - "x\n" → one `err` pulse, no `req`.
  - "r 00g00000\n" → `err` pulse on `g`, remaining bytes discarded up to LF, no `req`.
  - "r 000000001\n" → `err` on the 9th digit, no `req`.
- Recovery: after the malformed "r 12\n", send "r 00000010\n".
  - Expected: single `req` with `addr`=0x00000010.
- Backpressure and idle bytes: toggle `s_tvalid` randomly during a write; hold `ack` low for 20 cycles; pulse `ack` while in IDLE.
  - Expected: correct decode; `s_tready`=0 and `addr`/`wdata` stable during the stall; stray `ack` has no effect.
- Reset mid-REQ and mid-line:
  - `req` clears asynchronously; a following valid command decodes correctly.
  - Bare LF lines produce neither `req` nor `err`.

Source files
------------

// File: rtl/command_ascii_decoder_if.sv
// Byte-stream input and bus-request output bundle of the ASCII command decoder.
// master = decoder side, slave = UART/bus environment side.
interface command_ascii_decoder_if;
    logic        s_tvalid;
    logic [7:0]  s_tdata;
    logic        s_tready;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        err;

    modport master (
        input  s_tvalid, s_tdata, ack,
        output s_tready, req, we, addr, wdata, err
    );

    modport slave (
        output s_tvalid, s_tdata, ack,
        input  s_tready, req, we, addr, wdata, err
    );
endinterface

// File: rtl/command_ascii_decoder.sv
// Parses ASCII lines "r AAAAAAAA" / "w AAAAAAAA DDDDDDDD" into one held 32-bit bus request.
// Malformed lines pulse err once and are discarded up to the next LF.
module command_ascii_decoder (
    input  logic                           clk,
    input  logic                           reset,
    command_ascii_decoder_if.master        bus
);

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_R  = 8'h72;
    localparam logic [7:0] ASCII_W  = 8'h77;

    typedef enum logic [2:0] {
        S_IDLE, S_SP1, S_ADDR, S_SP2, S_DATA, S_EOL, S_REQ, S_DISCARD
    } state_t;

    state_t      r_state;
    logic        r_isWrite;
    logic [2:0]  r_count;
    logic [31:0] r_addrAcc;
    logic [31:0] r_dataAcc;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic        r_err;

    state_t      w_nextState;
    logic        w_accept;
    logic        w_isCr;
    logic        w_isHex;
    logic [3:0]  w_nibble;
    logic        w_error;
    logic        w_setType;
    logic        w_typeWrite;
    logic        w_clearCount;
    logic        w_shiftAddr;
    logic        w_shiftData;
    logic        w_loadOut;
    logic [7:0]  w_byte;

    assign w_byte   = bus.s_tdata;
    assign w_accept = bus.s_tvalid && bus.s_tready;
    assign w_isCr   = (w_byte == ASCII_CR);

    // Letters map through their low nibble: 'a'/'A' end in 1, so +9 gives 10.
    always_comb begin
        w_isHex  = 1'b1;
        w_nibble = 4'h0;
        if (w_byte >= 8'h30 && w_byte <= 8'h39) begin
            w_nibble = w_byte[3:0];
        end else if ((w_byte >= 8'h61 && w_byte <= 8'h66) ||
                     (w_byte >= 8'h41 && w_byte <= 8'h46)) begin
            w_nibble = w_byte[3:0] + 4'd9;
        end else begin
            w_isHex = 1'b0;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_error      = 1'b0;
        w_setType    = 1'b0;
        w_typeWrite  = 1'b0;
        w_clearCount = 1'b0;
        w_shiftAddr  = 1'b0;
        w_shiftData  = 1'b0;
        w_loadOut    = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept && !w_isCr) begin
                if (w_byte == ASCII_R) begin
                    w_nextState = S_SP1;
                    w_setType   = 1'b1;
                end else if (w_byte == ASCII_W) begin
                    w_nextState = S_SP1;
                    w_setType   = 1'b1;
                    w_typeWrite = 1'b1;
                end else if (w_byte != ASCII_LF) begin
                    w_error = 1'b1;
                end
            end
            S_SP1: if (w_accept && !w_isCr) begin
                if (w_byte == ASCII_SP) begin
                    w_nextState  = S_ADDR;
                    w_clearCount = 1'b1;
                end else begin
                    w_error = 1'b1;
                end
            end
            S_ADDR: if (w_accept && !w_isCr) begin
                if (w_isHex) begin
                    w_shiftAddr = 1'b1;
                    if (r_count == 3'd7) begin
                        w_nextState = r_isWrite ? S_SP2 : S_EOL;
                    end
                end else begin
                    w_error = 1'b1;
                end
            end
            S_SP2: if (w_accept && !w_isCr) begin
                if (w_byte == ASCII_SP) begin
                    w_nextState  = S_DATA;
                    w_clearCount = 1'b1;
                end else begin
                    w_error = 1'b1;
                end
            end
            S_DATA: if (w_accept && !w_isCr) begin
                if (w_isHex) begin
                    w_shiftData = 1'b1;
                    if (r_count == 3'd7) begin
                        w_nextState = S_EOL;
                    end
                end else begin
                    w_error = 1'b1;
                end
            end
            S_EOL: if (w_accept && !w_isCr) begin
                if (w_byte == ASCII_LF) begin
                    w_nextState = S_REQ;
                    w_loadOut   = 1'b1;
                end else begin
                    w_error = 1'b1;
                end
            end
            S_REQ: if (bus.ack) begin
                w_nextState = S_IDLE;
            end
            S_DISCARD: if (w_accept && w_byte == ASCII_LF) begin
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
        // The offending byte is consumed; an LF already closes the bad line.
        if (w_error) begin
            w_nextState = (w_byte == ASCII_LF) ? S_IDLE : S_DISCARD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_isWrite <= 1'b0;
            r_count   <= 3'd0;
            r_addrAcc <= 32'd0;
            r_dataAcc <= 32'd0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_err   <= w_error;
            if (w_setType) begin
                r_isWrite <= w_typeWrite;
            end
            // The counter wraps 7 -> 0 on the 8th digit, ready for the next field.
            if (w_clearCount) begin
                r_count <= 3'd0;
            end else if (w_shiftAddr || w_shiftData) begin
                r_count <= r_count + 3'd1;
            end
            if (w_shiftAddr) begin
                r_addrAcc <= {r_addrAcc[27:0], w_nibble};
            end
            if (w_shiftData) begin
                r_dataAcc <= {r_dataAcc[27:0], w_nibble};
            end
            if (w_loadOut) begin
                r_addr  <= r_addrAcc;
                r_wdata <= r_isWrite ? r_dataAcc : 32'd0;
                r_we    <= r_isWrite;
            end
        end
    end

    assign bus.s_tready = (r_state != S_REQ);
    assign bus.req      = (r_state == S_REQ);
    assign bus.we       = r_we;
    assign bus.addr     = r_addr;
    assign bus.wdata    = r_wdata;
    assign bus.err      = r_err;

endmodule
